uart_io_handler: RTL and testbench
==================================

# uart_io_handler

Protocol layer between the byte-level UART (or its simulation model) and the system bus master. It parses incoming ASCII-hex command packets into 32-bit command/address/data words. It also serialises 32-bit status/address/data responses back into ASCII-hex bytes for the UART transmitter. The RX parser and the TX serialiser run independently and concurrently.

## Interface
Parameters:
- ID_CHAR_IN, 8'h4C ('L'): start-of-packet character for incoming commands
- ID_CHAR_OUT, 8'h53 ('S'): start-of-packet character for outgoing responses
- TX_GUARD, 2: minimum idle cycles after each uart_transmit pulse before the next byte may be issued (1..15)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- uart_received  in  1  one-cycle strobe: uart_rx_byte valid
- uart_rx_byte  in  8  received byte
- uart_transmit  out  1  one-cycle strobe: send uart_tx_byte
- uart_tx_byte  out  8  byte to transmit; holds last value sent
- uart_is_transmitting  in  1  UART TX busy
- cmd_stb  out  1  one-cycle strobe: full command decoded
- cmd_command  out  32  decoded command word
- cmd_address  out  32  decoded address word
- cmd_data  out  32  decoded data word
- cmd_error  out  1  one-cycle strobe: packet aborted on a non-hex character
- resp_en  in  1  start a response; sampled only when resp_busy=0
- resp_status, resp_address, resp_data  in  32 each  response words
- resp_busy  out  1  response in flight

## Operation
- Reset: every output is 0. Both FSMs go to IDLE. Shift registers and nibble counters are cleared.
- Hex rule: accept only '0'-'9' (0x30-0x39, value = c-0x30) and 'A'-'F' (0x41-0x46, value = c-0x37). Lowercase and all other bytes are non-hex.
- Only cycles with uart_received=1 advance the RX FSM.
- RX FSM states: IDLE, COMMAND, ADDRESS, DATA.
- IDLE: ID_CHAR_IN moves to COMMAND with the nibble counter at 0. Any other byte is silently ignored; no error is raised.
- COMMAND/ADDRESS/DATA:
  - Each hex byte shifts into the field shift register at bits [3:0], after a left shift by 4, so the first character becomes the MSB nibble.
  - The 8th nibble of a field advances to the next field, or to IDLE after DATA.
- Completion: after the 8th DATA nibble, cmd_command/cmd_address/cmd_data load from the shift registers and cmd_stb pulses. The cmd_* words hold until the next cmd_stb.
- Abort: a non-hex byte in any field pulses cmd_error and returns to IDLE. That byte is not re-evaluated as ID_CHAR_IN. cmd_* keep their previous values.
- TX FSM states: IDLE, SEND, WAIT.
- IDLE: resp_en=1 latches the three resp_* words and sets resp_busy.
- SEND: pulse uart_transmit for one cycle with the current character. The sequence is 25 characters: ID_CHAR_OUT, then status, address, data nibbles from MSB to LSB, each as uppercase ASCII hex.
- WAIT: count TX_GUARD cycles, then wait until uart_is_transmitting=0. Then go to SEND for the next character, or to IDLE after the 25th, clearing resp_busy.
- resp_en while resp_busy=1 is ignored; the latched words are unaffected.

## Timing
- cmd_stb and cmd_* update in the cycle after the uart_received that carries the 24th hex character (1-cycle latency). cmd_error behaves the same relative to the offending byte.
- Back-to-back uart_received on consecutive cycles must be accepted with no loss.
- resp_en sampled at cycle 0 → resp_busy=1 and first uart_transmit ('S') at cycle 1.
- Consecutive uart_transmit pulses are at least TX_GUARD+1 cycles apart. They are exactly that far apart when uart_is_transmitting is held 0.
- resp_busy falls TX_GUARD+1 cycles after the 25th pulse, given uart_is_transmitting=0. A new resp_en may be accepted in that same cycle's successor.
- Async rst mid-packet: both FSMs abort immediately and outputs go to 0. No partial cmd_stb or uart_transmit follows deassertion.

## Test plan
- RX 'L',"00000001","01234567","89ABCDEF" → exactly one cmd_stb, 1 cycle after the last byte; cmd_command=0x00000001, cmd_address=0x01234567, cmd_data=0x89ABCDEF; cmd_error never asserted.
- RX 'L',"0000G" → cmd_error pulse 1 cycle after 'G', no cmd_stb, cmd_* unchanged. A following valid packet with data "0000000F" decodes cmd_data=0x0000000F.
- RX 'x','5','L',"0000000a"... → 'x','5' ignored with no error; lowercase 'a' raises cmd_error.
- resp_en with status 0x00000000, address 0xDEADBEEF, data 0x0000000A, uart_is_transmitting=0, TX_GUARD=2:
  - 25 pulses spaced 3 cycles apart, bytes 'S', '0'×8, "DEADBEEF", '0'×7, 'A'.
  - resp_busy high throughout.
  - A second resp_en at pulse 10 is ignored and sends nothing extra.
- Hold uart_is_transmitting=1 for 20 cycles after the 'S' pulse → next pulse occurs 1 cycle after it drops; byte order is unchanged.
- Assert rst mid-RX (after 12 nibbles) and mid-TX (after 10 bytes) → all outputs 0 immediately. After release, a full RX packet and a full response complete correctly.

Source files
------------

// File: rtl/uart_io_handler.sv
// uart_io_handler: ASCII-hex protocol layer between a byte UART and a bus master.
//   RX: parses ID_CHAR_IN followed by 24 hex characters into command/address/data
//       words and strobes cmd_stb; a non-hex character aborts with cmd_error.
//   TX: on resp_en, serialises ID_CHAR_OUT plus 24 hex characters of
//       status/address/data, observing a guard gap and the UART busy flag.
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   uart_received, uart_rx_byte   received byte strobe and value
//   uart_transmit, uart_tx_byte   transmit strobe and byte (byte holds last value)
//   uart_is_transmitting          UART transmitter busy
//   cmd_stb, cmd_error            decoded-packet / aborted-packet strobes
//   cmd_command/address/data      decoded words, held until the next cmd_stb
//   resp_en, resp_status/address/data  response request and words
//   resp_busy                     response in flight
module uart_io_handler #(
   parameter logic [7:0]  ID_CHAR_IN  = 8'h4C,
   parameter logic [7:0]  ID_CHAR_OUT = 8'h53,
   parameter int unsigned TX_GUARD    = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        uart_received,
   input  logic [7:0]  uart_rx_byte,
   output logic        uart_transmit,
   output logic [7:0]  uart_tx_byte,
   input  logic        uart_is_transmitting,
   output logic        cmd_stb,
   output logic [31:0] cmd_command,
   output logic [31:0] cmd_address,
   output logic [31:0] cmd_data,
   output logic        cmd_error,
   input  logic        resp_en,
   input  logic [31:0] resp_status,
   input  logic [31:0] resp_address,
   input  logic [31:0] resp_data,
   output logic        resp_busy
);

   localparam int unsigned WORD_W  = 32;
   localparam int unsigned NIB_W   = 3;
   localparam int unsigned GUARD_W = 4;
   localparam int unsigned CHAR_W  = 5;
   localparam int unsigned RESP_W  = 3 * WORD_W;
   localparam logic [NIB_W-1:0]   LAST_NIB   = NIB_W'(7);
   localparam logic [CHAR_W-1:0]  LAST_CHAR  = CHAR_W'(24);
   localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(TX_GUARD - 1);

   typedef enum logic [1:0] {RX_IDLE, RX_COMMAND, RX_ADDRESS, RX_DATA} rx_state_t;
   typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_WAIT} tx_state_t;

   rx_state_t           rx_state, rx_state_d;
   logic [NIB_W-1:0]    rx_cnt, rx_cnt_d;
   logic [WORD_W-1:0]   sh_cmd, sh_cmd_d, sh_addr, sh_addr_d, sh_data, sh_data_d;
   logic [WORD_W-1:0]   cmd_command_d, cmd_address_d, cmd_data_d;
   logic                cmd_stb_d, cmd_error_d;

   tx_state_t           tx_state, tx_state_d;
   logic [RESP_W-1:0]   resp_sh, resp_sh_d;
   logic [CHAR_W-1:0]   char_idx, char_idx_d;
   logic [GUARD_W-1:0]  guard, guard_d;
   logic                uart_transmit_d, resp_busy_d;
   logic [7:0]          uart_tx_byte_d;

   logic                rx_is_hex;
   logic [3:0]          rx_nib;

   // Uppercase-only hex decode of the received byte
   always_comb begin
      rx_is_hex = 1'b0;
      rx_nib    = 4'h0;
      if (uart_rx_byte >= 8'h30 && uart_rx_byte <= 8'h39) begin
         rx_is_hex = 1'b1;
         rx_nib    = uart_rx_byte[3:0];
      end else if (uart_rx_byte >= 8'h41 && uart_rx_byte <= 8'h46) begin
         rx_is_hex = 1'b1;
         rx_nib    = uart_rx_byte[3:0] + 4'd9;
      end
   end

   function automatic logic [7:0] nib_to_ascii(input logic [3:0] n);
      return (n < 4'd10) ? {4'h3, n} : (8'h37 + 8'(n));
   endfunction

   // RX parser next state
   always_comb begin
      rx_state_d    = rx_state;
      rx_cnt_d      = rx_cnt;
      sh_cmd_d      = sh_cmd;
      sh_addr_d     = sh_addr;
      sh_data_d     = sh_data;
      cmd_command_d = cmd_command;
      cmd_address_d = cmd_address;
      cmd_data_d    = cmd_data;
      cmd_stb_d     = 1'b0;
      cmd_error_d   = 1'b0;
      if (uart_received) begin
         if (rx_state == RX_IDLE) begin
            if (uart_rx_byte == ID_CHAR_IN) begin
               rx_state_d = RX_COMMAND;
               rx_cnt_d   = '0;
            end
         end else if (!rx_is_hex) begin
            // Offending byte is consumed here, never re-read as a start char
            cmd_error_d = 1'b1;
            rx_state_d  = RX_IDLE;
            rx_cnt_d    = '0;
         end else begin
            case (rx_state)
               RX_COMMAND: sh_cmd_d  = {sh_cmd[WORD_W-5:0], rx_nib};
               RX_ADDRESS: sh_addr_d = {sh_addr[WORD_W-5:0], rx_nib};
               RX_DATA:    sh_data_d = {sh_data[WORD_W-5:0], rx_nib};
               default:    ;
            endcase
            if (rx_cnt == LAST_NIB) begin
               rx_cnt_d = '0;
               case (rx_state)
                  RX_COMMAND: rx_state_d = RX_ADDRESS;
                  RX_ADDRESS: rx_state_d = RX_DATA;
                  default: begin
                     rx_state_d    = RX_IDLE;
                     cmd_command_d = sh_cmd;
                     cmd_address_d = sh_addr;
                     cmd_data_d    = sh_data_d;
                     cmd_stb_d     = 1'b1;
                  end
               endcase
            end else begin
               rx_cnt_d = rx_cnt + NIB_W'(1);
            end
         end
      end
   end

   // TX serialiser next state; uart_transmit is raised on entry to SEND
   always_comb begin
      tx_state_d      = tx_state;
      resp_sh_d       = resp_sh;
      char_idx_d      = char_idx;
      guard_d         = guard;
      uart_transmit_d = 1'b0;
      uart_tx_byte_d  = uart_tx_byte;
      resp_busy_d     = resp_busy;
      case (tx_state)
         TX_IDLE: begin
            if (resp_en) begin
               resp_sh_d       = {resp_status, resp_address, resp_data};
               resp_busy_d     = 1'b1;
               uart_transmit_d = 1'b1;
               uart_tx_byte_d  = ID_CHAR_OUT;
               char_idx_d      = '0;
               tx_state_d      = TX_SEND;
            end
         end
         TX_SEND: begin
            guard_d    = '0;
            tx_state_d = TX_WAIT;
         end
         TX_WAIT: begin
            if (guard < GUARD_LAST) guard_d = guard + GUARD_W'(1);
            if (guard == GUARD_LAST && !uart_is_transmitting) begin
               if (char_idx == LAST_CHAR) begin
                  resp_busy_d = 1'b0;
                  tx_state_d  = TX_IDLE;
               end else begin
                  uart_transmit_d = 1'b1;
                  uart_tx_byte_d  = nib_to_ascii(resp_sh[RESP_W-1 -: 4]);
                  resp_sh_d       = {resp_sh[RESP_W-5:0], 4'h0};
                  char_idx_d      = char_idx + CHAR_W'(1);
                  tx_state_d      = TX_SEND;
               end
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
   end

   // State and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state      <= RX_IDLE;
         rx_cnt        <= '0;
         sh_cmd        <= '0;
         sh_addr       <= '0;
         sh_data       <= '0;
         cmd_command   <= '0;
         cmd_address   <= '0;
         cmd_data      <= '0;
         cmd_stb       <= 1'b0;
         cmd_error     <= 1'b0;
         tx_state      <= TX_IDLE;
         resp_sh       <= '0;
         char_idx      <= '0;
         guard         <= '0;
         uart_transmit <= 1'b0;
         uart_tx_byte  <= '0;
         resp_busy     <= 1'b0;
      end else begin
         rx_state      <= rx_state_d;
         rx_cnt        <= rx_cnt_d;
         sh_cmd        <= sh_cmd_d;
         sh_addr       <= sh_addr_d;
         sh_data       <= sh_data_d;
         cmd_command   <= cmd_command_d;
         cmd_address   <= cmd_address_d;
         cmd_data      <= cmd_data_d;
         cmd_stb       <= cmd_stb_d;
         cmd_error     <= cmd_error_d;
         tx_state      <= tx_state_d;
         resp_sh       <= resp_sh_d;
         char_idx      <= char_idx_d;
         guard         <= guard_d;
         uart_transmit <= uart_transmit_d;
         uart_tx_byte  <= uart_tx_byte_d;
         resp_busy     <= resp_busy_d;
      end
   end

endmodule

// File: tb/tb_uart_io_handler.sv
// Scoreboard bench for uart_io_handler: packets and responses are built from
// words, expected events are queued at issue time, and negedge monitors pop and
// compare whenever the DUT strobes cmd_stb/cmd_error or uart_transmit.
module tb_uart_io_handler;
   localparam int unsigned TX_GUARD = 2;
   localparam logic [7:0]  ID_IN    = 8'h4C;
   localparam logic [7:0]  ID_OUT   = 8'h53;

   logic        clk, rst;
   logic        uart_received;
   logic [7:0]  uart_rx_byte;
   logic        uart_transmit;
   logic [7:0]  uart_tx_byte;
   logic        uart_is_transmitting;
   logic        cmd_stb, cmd_error;
   logic [31:0] cmd_command, cmd_address, cmd_data;
   logic        resp_en;
   logic [31:0] resp_status, resp_address, resp_data;
   logic        resp_busy;

   uart_io_handler #(.ID_CHAR_IN(ID_IN), .ID_CHAR_OUT(ID_OUT), .TX_GUARD(TX_GUARD)) dut (
      .clk(clk), .rst(rst),
      .uart_received(uart_received), .uart_rx_byte(uart_rx_byte),
      .uart_transmit(uart_transmit), .uart_tx_byte(uart_tx_byte),
      .uart_is_transmitting(uart_is_transmitting),
      .cmd_stb(cmd_stb), .cmd_command(cmd_command), .cmd_address(cmd_address),
      .cmd_data(cmd_data), .cmd_error(cmd_error),
      .resp_en(resp_en), .resp_status(resp_status), .resp_address(resp_address),
      .resp_data(resp_data), .resp_busy(resp_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {bit err; logic [31:0] c; logic [31:0] a; logic [31:0] d; int cyc;} rx_exp_t;
   typedef struct {logic [7:0] b; int cyc;} tx_exp_t;

   rx_exp_t rx_q[$];
   tx_exp_t tx_q[$];
   rx_exp_t mon_e;
   tx_exp_t mon_t;
   int tests = 0;
   int fails = 0;
   int tx_seen = 0;
   int exp_next = 0;
   int busy_chk = -1;
   logic [31:0] good_c = '0, good_a = '0, good_d = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout_fail(input string name);
      tests++;
      fails++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      string digits;
      digits = "0123456789ABCDEF";
      return digits[n];
   endfunction

   function automatic bit is_hex(input logic [7:0] b);
      return (b >= 8'h30 && b <= 8'h39) || (b >= 8'h41 && b <= 8'h46);
   endfunction

   function automatic logic [7:0] rand_bad();
      logic [7:0] specials [7];
      logic [7:0] b;
      specials = '{8'h4C, 8'h61, 8'h47, 8'h3A, 8'h40, 8'h2F, 8'h66};
      if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 6)];
      b = 8'($urandom);
      while (is_hex(b)) b = 8'($urandom);
      return b;
   endfunction

   task automatic idle_cycles(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic rx_byte(input logic [7:0] b);
      uart_received = 1'b1;
      uart_rx_byte  = b;
      @(posedge clk); #1;
      uart_received = 1'b0;
   endtask

   // Sends ID_IN plus the 24 characters of {c,a,d}; err_pos>=0 replaces that
   // character with a non-hex byte and ends the packet there.
   task automatic rx_packet(input logic [31:0] c, input logic [31:0] a, input logic [31:0] d,
                            input int err_pos, input logic [7:0] bad, input bit b2b);
      logic [95:0] w;
      rx_exp_t e;
      w = {c, a, d};
      rx_byte(ID_IN);
      for (int i = 0; i < 24; i++) begin
         if (!b2b) idle_cycles($urandom_range(0, 2));
         if (i == err_pos) begin
            e = '{1'b1, good_c, good_a, good_d, cyc + 1};
            rx_q.push_back(e);
            rx_byte(bad);
            return;
         end
         if (i == 23) begin
            good_c = c; good_a = a; good_d = d;
            e = '{1'b0, c, a, d, cyc + 1};
            rx_q.push_back(e);
         end
         rx_byte(hex_char(w[95 - 4*i -: 4]));
      end
   endtask

   task automatic rx_noise();
      logic [7:0] b;
      repeat ($urandom_range(0, 2)) begin
         b = 8'($urandom);
         if (b == ID_IN) b = 8'h00;
         rx_byte(b);
      end
   endtask

   task automatic send_resp(input logic [31:0] s, input logic [31:0] a, input logic [31:0] d);
      int g;
      logic [95:0] w;
      tx_exp_t t;
      g = 0;
      while (resp_busy === 1'b1) begin
         if (g++ > 3000) begin timeout_fail("tx_wait_idle"); return; end
         @(posedge clk); #1;
      end
      resp_en = 1'b1;
      resp_status = s; resp_address = a; resp_data = d;
      w = {s, a, d};
      t = '{ID_OUT, cyc + 1};
      tx_q.push_back(t);
      for (int i = 0; i < 24; i++) begin
         t = '{hex_char(w[95 - 4*i -: 4]), -1};
         tx_q.push_back(t);
      end
      @(posedge clk); #1;
      resp_en = 1'b0;
      resp_status = $urandom; resp_address = $urandom; resp_data = $urandom;
   endtask

   task automatic wait_tx_done();
      int g;
      g = 0;
      while (tx_q.size() != 0 || resp_busy !== 1'b0 || busy_chk != -1) begin
         if (g++ > 5000) begin timeout_fail("tx_done"); return; end
         @(posedge clk); #1;
      end
   endtask

   task automatic wait_rx_done();
      int g;
      g = 0;
      while (rx_q.size() != 0) begin
         if (g++ > 200) begin timeout_fail("rx_done"); return; end
         @(posedge clk); #1;
      end
      idle_cycles(2);
   endtask

   // Monitors: compare DUT strobes against queued expectations
   always @(negedge clk) begin
      if (!rst) begin
         if (cmd_stb || cmd_error) begin
            if (rx_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL rx_unexpected: got stb=%b err=%b expected no strobe (cycle %0d)",
                        cmd_stb, cmd_error, cyc);
            end else begin
               mon_e = rx_q.pop_front();
               check("rx_kind", {30'b0, cmd_stb, cmd_error}, {30'b0, ~mon_e.err, mon_e.err});
               check("rx_latency", cyc, mon_e.cyc);
               check("cmd_command", cmd_command, mon_e.c);
               check("cmd_address", cmd_address, mon_e.a);
               check("cmd_data", cmd_data, mon_e.d);
            end
         end
         if (uart_transmit) begin
            if (tx_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL tx_unexpected: got byte 0x%02h expected no pulse (cycle %0d)",
                        uart_tx_byte, cyc);
            end else begin
               mon_t = tx_q.pop_front();
               check("tx_byte", 32'(uart_tx_byte), 32'(mon_t.b));
               check("tx_timing", cyc, (mon_t.cyc >= 0) ? mon_t.cyc : exp_next);
               check("tx_busy_during", 32'(resp_busy), 32'd1);
               exp_next = cyc + TX_GUARD + 1;
               tx_seen++;
               if (tx_q.size() == 0) busy_chk = cyc + TX_GUARD + 1;
            end
         end
         if (busy_chk != -1) begin
            if (cyc == busy_chk) begin
               check("resp_busy_fall", 32'(resp_busy), 32'd0);
               busy_chk = -1;
            end else if (!uart_transmit) begin
               check("resp_busy_tail", 32'(resp_busy), 32'd1);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
      $fatal(1);
   end

   task automatic check_outputs_zero(input string tag);
      check({tag, "_uart_transmit"}, 32'(uart_transmit), 32'd0);
      check({tag, "_uart_tx_byte"}, 32'(uart_tx_byte), 32'd0);
      check({tag, "_cmd_stb"}, 32'(cmd_stb), 32'd0);
      check({tag, "_cmd_error"}, 32'(cmd_error), 32'd0);
      check({tag, "_cmd_command"}, cmd_command, 32'd0);
      check({tag, "_cmd_address"}, cmd_address, 32'd0);
      check({tag, "_cmd_data"}, cmd_data, 32'd0);
      check({tag, "_resp_busy"}, 32'(resp_busy), 32'd0);
   endtask

   initial begin
      int base;
      int g;
      rst = 1'b1;
      uart_received = 1'b0; uart_rx_byte = '0; uart_is_transmitting = 1'b0;
      resp_en = 1'b0; resp_status = '0; resp_address = '0; resp_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_outputs_zero("reset");
      rst = 1'b0;
      idle_cycles(2);

      // Directed RX cases
      rx_packet(32'h00000001, 32'h01234567, 32'h89ABCDEF, -1, 8'h00, 1'b1);
      idle_cycles(3);
      rx_packet(32'h00000000, 32'h0, 32'h0, 4, 8'h47, 1'b1);
      rx_packet(32'hA5A5_0F0F, 32'h1357_9BDF, 32'h0000000F, -1, 8'h00, 1'b1);
      rx_byte(8'h78);
      rx_byte(8'h35);
      rx_packet(32'h00000000, 32'h0, 32'h0, 7, 8'h61, 1'b1);
      wait_rx_done();

      // Directed TX with an ignored resp_en at pulse 10
      base = tx_seen;
      fork
         send_resp(32'h00000000, 32'hDEADBEEF, 32'h0000000A);
         begin
            g = 0;
            while (tx_seen < base + 10 && g < 200) begin g++; @(posedge clk); #1; end
            if (g >= 200) timeout_fail("tx_pulse10");
            resp_en = 1'b1;
            resp_status = 32'hFFFFFFFF; resp_address = 32'hFFFFFFFF; resp_data = 32'hFFFFFFFF;
            @(posedge clk); #1;
            resp_en = 1'b0;
         end
      join
      wait_tx_done();
      idle_cycles(2);

      // Busy UART held after the start character
      fork
         send_resp($urandom, $urandom, $urandom);
         begin
            g = 0;
            @(negedge clk);
            while (!uart_transmit && g < 50) begin g++; @(negedge clk); end
            if (g >= 50) timeout_fail("tx_hold_start");
            uart_is_transmitting = 1'b1;
            repeat (20) @(posedge clk);
            #1;
            uart_is_transmitting = 1'b0;
            exp_next = cyc + 1;
         end
      join
      wait_tx_done();

      // Randomized concurrent RX and TX traffic
      fork
         begin
            for (int p = 0; p < 30; p++) begin
               rx_noise();
               if ($urandom_range(0, 3) == 0)
                  rx_packet($urandom, $urandom, $urandom, $urandom_range(0, 23), rand_bad(),
                            1'($urandom_range(0, 1)));
               else
                  rx_packet($urandom, $urandom, $urandom, -1, 8'h00, 1'($urandom_range(0, 1)));
            end
         end
         begin
            for (int r = 0; r < 4; r++) begin
               send_resp($urandom, $urandom, $urandom);
               idle_cycles($urandom_range(0, 5));
            end
         end
      join
      wait_rx_done();
      wait_tx_done();

      // Asynchronous reset in the middle of an RX packet and a response
      base = tx_seen;
      send_resp($urandom, $urandom, $urandom);
      rx_byte(ID_IN);
      for (int i = 0; i < 12; i++) rx_byte(hex_char(4'($urandom)));
      g = 0;
      while (tx_seen < base + 10 && g < 200) begin g++; @(posedge clk); #1; end
      if (g >= 200) timeout_fail("tx_reset_point");
      @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check_outputs_zero("midrst");
      tx_q.delete();
      rx_q.delete();
      busy_chk = -1;
      good_c = '0; good_a = '0; good_d = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      idle_cycles(3);
      fork
         rx_packet($urandom, $urandom, $urandom, -1, 8'h00, 1'b0);
         send_resp($urandom, $urandom, $urandom);
      join
      wait_rx_done();
      wait_tx_done();

      check("rx_queue_empty", 32'(rx_q.size()), 32'd0);
      check("tx_queue_empty", 32'(tx_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
